// File: rtl/gpio_pio_ctrl.sv
// Parametrised GPIO/key controller: synchronised, debounced inputs with edge capture and
// maskable interrupt, plus set/clear-capable outputs, behind an Avalon-MM slave.
module gpio_pio_ctrl #(
    parameter int unsigned     N_IN            = 4,
    parameter int unsigned     N_OUT           = 8,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter int unsigned     DEBOUNCE_CYCLES = 50000,
    parameter logic [N_IN-1:0]  IN_RST         = '1,
    parameter logic [N_OUT-1:0] OUT_RST        = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [N_IN-1:0]  pio_in,
    output logic [N_OUT-1:0] pio_out
);

    localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] A_DATA_IN  = 3'd0;
    localparam logic [2:0] A_DATA_OUT = 3'd1;
    localparam logic [2:0] A_OUT_SET  = 3'd2;
    localparam logic [2:0] A_OUT_CLR  = 3'd3;
    localparam logic [2:0] A_IRQ_MASK = 3'd4;
    localparam logic [2:0] A_EDGE_CAP = 3'd5;
    localparam logic [2:0] A_EDGE_SEL = 3'd6;
    localparam logic [2:0] A_ID       = 3'd7;

    logic [N_IN-1:0]  sync_q [SYNC_STAGES];
    logic [N_IN-1:0]  sync_d [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [N_IN];
    logic [CNT_W-1:0] cnt_d  [N_IN];
    logic [N_IN-1:0]  stable_q, stable_d;
    logic [N_IN-1:0]  prev_q, prev_d;
    logic [N_IN-1:0]  mask_q, mask_d;
    logic [N_IN-1:0]  sel_rise_q, sel_rise_d;
    logic [N_IN-1:0]  sel_fall_q, sel_fall_d;
    logic [N_IN-1:0]  cap_q, cap_d;
    logic [N_OUT-1:0] out_q, out_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [N_IN-1:0]  set_c;
    logic [N_IN-1:0]  w1c_c;
    logic [31:0]      rd_mux_c;
    logic             unused_wdata_c;

    assign unused_wdata_c = ^avs_writedata;

    // Synchroniser chain and per-channel debounce counters
    always_comb begin
        sync_d[0] = pio_in;
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_d[s] = sync_q[s-1];
        end
        stable_d = stable_q;
        for (int i = 0; i < int'(N_IN); i++) begin
            cnt_d[i] = '0;
            if (sync_q[SYNC_STAGES-1][i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync_q[SYNC_STAGES-1][i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge capture, interrupt and register writes
    always_comb begin
        set_c      = ((stable_q & ~prev_q) & sel_rise_q) | ((~stable_q & prev_q) & sel_fall_q);
        w1c_c      = '0;
        prev_d     = stable_q;
        irq_d      = |(cap_q & mask_q);
        out_d      = out_q;
        mask_d     = mask_q;
        sel_rise_d = sel_rise_q;
        sel_fall_d = sel_fall_q;
        if (avs_write) begin
            case (avs_address)
                A_DATA_OUT: out_d  = avs_writedata[N_OUT-1:0];
                A_OUT_SET:  out_d  = out_q | avs_writedata[N_OUT-1:0];
                A_OUT_CLR:  out_d  = out_q & ~avs_writedata[N_OUT-1:0];
                A_IRQ_MASK: mask_d = avs_writedata[N_IN-1:0];
                A_EDGE_CAP: w1c_c  = avs_writedata[N_IN-1:0];
                A_EDGE_SEL: begin
                    sel_rise_d = avs_writedata[N_IN-1:0];
                    sel_fall_d = avs_writedata[16 +: N_IN];
                end
                default: ;
            endcase
        end
        // a fresh edge wins over a same-cycle clear
        cap_d = (cap_q & ~w1c_c) | set_c;
    end

    // Read mux sees pre-write register values
    always_comb begin
        rd_mux_c = '0;
        case (avs_address)
            A_DATA_IN:  rd_mux_c[N_IN-1:0]  = stable_q;
            A_DATA_OUT: rd_mux_c[N_OUT-1:0] = out_q;
            A_IRQ_MASK: rd_mux_c[N_IN-1:0]  = mask_q;
            A_EDGE_CAP: rd_mux_c[N_IN-1:0]  = cap_q;
            A_EDGE_SEL: begin
                rd_mux_c[N_IN-1:0]  = sel_rise_q;
                rd_mux_c[16 +: N_IN] = sel_fall_q;
            end
            A_ID:       rd_mux_c = {8'h00, 8'hA5, 8'(N_OUT), 8'(N_IN)};
            default:    rd_mux_c = '0;
        endcase
        rdata_d = avs_read ? rd_mux_c : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= IN_RST;
            end
            for (int i = 0; i < int'(N_IN); i++) begin
                cnt_q[i] <= '0;
            end
            stable_q   <= IN_RST;
            prev_q     <= IN_RST;
            mask_q     <= '0;
            sel_rise_q <= '0;
            sel_fall_q <= '0;
            cap_q      <= '0;
            out_q      <= OUT_RST;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < int'(N_IN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q   <= stable_d;
            prev_q     <= prev_d;
            mask_q     <= mask_d;
            sel_rise_q <= sel_rise_d;
            sel_fall_q <= sel_fall_d;
            cap_q      <= cap_d;
            out_q      <= out_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign pio_out      = out_q;

endmodule

// File: tb/tb_gpio_pio_ctrl.sv
// Directed plus randomized bench for gpio_pio_ctrl against a cycle-level behavioural model.
module tb_gpio_pio_ctrl;

    localparam int unsigned N_IN  = 4;
    localparam int unsigned N_OUT = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       avs_address = '0;
    logic             avs_read = 1'b0;
    logic             avs_write = 1'b0;
    logic [31:0]      avs_writedata = '0;
    logic [31:0]      avs_readdata;
    logic             irq;
    logic [N_IN-1:0]  pio_in = '1;
    logic [N_OUT-1:0] pio_out;

    int tests = 0;
    int fails = 0;

    gpio_pio_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .IN_RST(4'hF), .OUT_RST(8'h00)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .irq(irq), .pio_in(pio_in), .pio_out(pio_out)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [N_IN-1:0]  m_pipe [SYNC];
    int               m_run  [N_IN];
    logic [N_IN-1:0]  m_stable, m_prev, m_cap, m_mask, m_rise, m_fall;
    logic [N_OUT-1:0] m_out;
    logic             m_irq;
    logic [31:0]      m_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            3'd0: v = {28'h0, m_stable};
            3'd1: v = {24'h0, m_out};
            3'd4: v = {28'h0, m_mask};
            3'd5: v = {28'h0, m_cap};
            3'd6: v = {12'h0, m_fall, 12'h0, m_rise};
            3'd7: v = 32'h00A5_0804;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic model_edge();
        logic [N_IN-1:0] s_old, sync_val, went_up, went_down, clr;
        logic            irq_new;
        if (!reset_n) begin
            for (int k = 0; k < int'(SYNC); k++) m_pipe[k] = 4'hF;
            for (int i = 0; i < int'(N_IN); i++) m_run[i] = 0;
            m_stable = 4'hF; m_prev = 4'hF; m_cap = '0; m_mask = '0;
            m_rise = '0; m_fall = '0; m_out = '0; m_irq = 1'b0; m_rd = '0;
        end else begin
            s_old = m_stable;
            if (avs_read) m_rd = m_read(avs_address);
            sync_val = m_pipe[SYNC-1];
            for (int k = int'(SYNC) - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = pio_in;
            // accept a level once it has disagreed for DEB consecutive cycles
            for (int i = 0; i < int'(N_IN); i++) begin
                if (sync_val[i] != s_old[i]) begin
                    m_run[i]++;
                    if (m_run[i] == int'(DEB)) begin
                        m_stable[i] = sync_val[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            went_up   = s_old & ~m_prev;
            went_down = ~s_old & m_prev;
            irq_new   = (m_cap & m_mask) != '0;
            clr       = (avs_write && avs_address == 3'd5) ? avs_writedata[3:0] : 4'h0;
            m_cap     = (m_cap & ~clr) | (went_up & m_rise) | (went_down & m_fall);
            m_prev    = s_old;
            m_irq     = irq_new;
            if (avs_write) begin
                case (avs_address)
                    3'd1: m_out = avs_writedata[7:0];
                    3'd2: m_out = m_out | avs_writedata[7:0];
                    3'd3: m_out = m_out & ~avs_writedata[7:0];
                    3'd4: m_mask = avs_writedata[3:0];
                    3'd6: begin m_rise = avs_writedata[3:0]; m_fall = avs_writedata[19:16]; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("pio_out", 32'(pio_out), 32'(m_out));
        check("irq", 32'(irq), 32'(m_irq));
        check("readdata", avs_readdata, m_rd);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    initial begin
        logic [31:0] d;
        int r;

        // reset and ID
        reset_n = 1'b0;
        ticks(3);
        check("rst_pio_out", 32'(pio_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        rd(3'd7, d); check("id", d, 32'h00A5_0804);
        rd(3'd0, d); check("data_in_rst", d, 32'h0000_000F);
        rd(3'd2, d); check("out_set_read", d, 32'h0);

        // debounce: 3-cycle glitch rejected, held press accepted after exactly 6 cycles
        pio_in[0] = 1'b0; ticks(3);
        pio_in[0] = 1'b1; ticks(8);
        rd(3'd0, d); check("glitch_rejected", d, 32'h0000_000F);
        pio_in[0] = 1'b0; ticks(5);
        rd(3'd0, d); check("press_not_yet", d, 32'h0000_000F);
        rd(3'd0, d); check("press_accepted", d, 32'h0000_000E);
        pio_in[0] = 1'b1; ticks(10);

        // falling-edge capture and interrupt
        wr(3'd6, 32'h0001_0000);
        wr(3'd4, 32'h1);
        pio_in[0] = 1'b0; ticks(6);
        check("irq_before_cap", 32'(irq), 32'h0);
        rd(3'd5, d); check("cap_pre", d, 32'h0);
        check("irq_pre", 32'(irq), 32'h0);
        rd(3'd5, d); check("cap_set", d, 32'h1);
        check("irq_set", 32'(irq), 32'h1);
        wr(3'd5, 32'h1);
        tick();
        check("irq_cleared", 32'(irq), 32'h0);
        rd(3'd5, d); check("cap_cleared", d, 32'h0);
        pio_in[0] = 1'b1; ticks(10);
        rd(3'd5, d); check("rise_ignored", d, 32'h0);
        check("irq_rise", 32'(irq), 32'h0);

        // set beats same-cycle clear
        pio_in[0] = 1'b0; ticks(6);
        wr(3'd5, 32'h1);
        rd(3'd5, d); check("set_beats_clear", d, 32'h1);
        wr(3'd5, 32'h1);
        tick();
        check("irq_after_clear", 32'(irq), 32'h0);

        // output operations
        wr(3'd1, 32'h0F); wr(3'd2, 32'hA0); wr(3'd3, 32'h03);
        check("out_ops", 32'(pio_out), 32'hAC);
        rd(3'd2, d); check("out_set_reads0", d, 32'h0);
        rd(3'd3, d); check("out_clr_reads0", d, 32'h0);
        wr(3'd1, 32'hFFFF_FF55);
        check("out_wide_write", 32'(pio_out), 32'h55);
        rd(3'd1, d); check("data_out_read", d, 32'h55);
        wr(3'd1, 32'hAC);

        // reset in the middle of a debounce count
        pio_in[1] = 1'b0; ticks(4);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("midrst_pio_out", 32'(pio_out), 32'h0);
        rd(3'd0, d); check("midrst_stable", d, 32'h0000_000F);
        ticks(4);
        rd(3'd0, d); check("restart_not_yet", d, 32'h0000_000F);
        rd(3'd0, d); check("restart_accepted", d, 32'h0000_000C);
        pio_in = 4'hF; ticks(10);

        // randomized traffic against the model
        wr(3'd6, 32'h000F_000F);
        wr(3'd4, 32'hF);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 11) == 0) pio_in[$urandom_range(0, N_IN-1)] ^= 1'b1;
            r = int'($urandom_range(0, 5));
            avs_read      = (r == 1) || (r == 3);
            avs_write     = (r == 2) || (r == 3);
            avs_address   = 3'($urandom_range(0, 7));
            avs_writedata = $urandom();
            reset_n       = ($urandom_range(0, 399) != 0);
            tick();
        end
        avs_read = 1'b0; avs_write = 1'b0; reset_n = 1'b1;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpio_pio_ctrl.md
Name: gpio_pio_ctrl

Overview:
Parametrised GPIO/key controller for the Qsys system. It replaces the fixed single-bit key PIO and single-bit GPIO output with N_IN synchronised, debounced inputs and N_OUT outputs, all behind an Avalon-MM slave. Each input channel has per-channel rising/falling edge capture and a maskable interrupt. Outputs support atomic set/clear writes.

Parameters:
N_IN, 4, number of input channels (1..16)
N_OUT, 8, number of output channels (1..32)
SYNC_STAGES, 2, input synchroniser depth (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept an input change (>=1)
IN_RST, all ones, reset value of the debounced input register (N_IN bits; DE2 keys idle high)
OUT_RST, 0, reset value of the output register (N_OUT bits)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
avs_address  input  3  word address
avs_read  input  1  read strobe
avs_write  input  1  write strobe
avs_writedata  input  32  write data
avs_readdata  output  32  read data, fixed read latency 1
irq  output  1  level interrupt, registered
pio_in  input  N_IN  asynchronous input pins
pio_out  output  N_OUT  output pins, driven directly from the output register

Behaviour:
- Clock and reset: single clock clk. reset_n is synchronous and active-low, sampled on the rising clk edge.
- Reset values:
  - sync chain = IN_RST; stable = IN_RST; debounce counters = 0.
  - pio_out = OUT_RST; irq_mask = 0; edge_sel = 0; edge_cap = 0.
  - irq = 0; avs_readdata = 0.
- Debounce, per channel:
  - sync = last stage of the SYNC_STAGES flop chain.
  - If sync == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync and cnt <= 0.
  - Else: cnt++.
  - A mismatch shorter than DEBOUNCE_CYCLES leaves stable unchanged.
  - Counter width = clog2(DEBOUNCE_CYCLES), minimum 1.
- Latency from a pin change held steady: stable updates SYNC_STAGES+DEBOUNCE_CYCLES cycles after the pin edge. edge_cap sets 1 cycle later. irq asserts 1 cycle after that.
- Edge detect: rise = stable_now & ~stable_prev; fall = ~stable_now & stable_prev.
  - edge_cap[i] is set when (rise[i] & edge_sel[i]) | (fall[i] & edge_sel[16+i]).
  - Set has priority over a same-cycle write-1-to-clear.
- irq <= |(edge_cap & irq_mask), registered.
- Register map (word address):
  - 0 DATA_IN, RO: stable.
  - 1 DATA_OUT, RW: the output register.
  - 2 OUT_SET, WO: out |= wdata.
  - 3 OUT_CLR, WO: out &= ~wdata.
  - 4 IRQ_MASK, RW: bits [N_IN-1:0].
  - 5 EDGE_CAP, R/W1C: a read does not clear.
  - 6 EDGE_SEL, RW: [N_IN-1:0] rising enables; [16+N_IN-1:16] falling enables.
  - 7 ID, RO: {8'h00, 8'hA5, N_OUT[7:0], N_IN[7:0]}.
- Bus rules:
  - Read: avs_readdata updates on the cycle after avs_read and holds until the next read.
  - Unused and unimplemented bits read 0.
  - Writes to RO addresses are ignored. Reads of WO addresses (2, 3) return 0.
  - Simultaneous read and write at the same cycle: the write is performed and the read returns the pre-write value.
  - Writes to bits above N_OUT/N_IN are ignored.
- Reset mid-operation: all debounce progress is discarded, pending edges are lost, and pio_out returns to OUT_RST on the same edge.

Test Plan:
1. Reset/ID (N_IN=4, N_OUT=8, DEBOUNCE_CYCLES=4):
   - Release reset, read addr 7 -> 32'h00A5_0804.
   - Read addr 0 -> 32'h0000_000F. pio_out = 0. irq = 0.
2. Debounce accept/reject:
   - Drive pio_in[0]=0 for 3 cycles then back to 1 -> DATA_IN stays 4'hF.
   - Hold pio_in[0]=0 -> stable[0] falls exactly 6 cycles after the pin edge; DATA_IN reads 4'hE.
3. Edge capture and IRQ:
   - Setup: EDGE_SEL=32'h0001_0000 (falling ch0), IRQ_MASK=1.
   - Press ch0 -> EDGE_CAP=1 at stable+1 cycle, irq=1 one cycle later.
   - Write 1 to addr 5 -> EDGE_CAP=0, irq=0 the following cycle.
   - A rising edge on ch0 does not set EDGE_CAP.
4. Clear/set collision: write addr 5 = 1 on the same cycle a selected edge occurs on ch0 -> EDGE_CAP[0] remains 1.
5. Output ops:
   - Write DATA_OUT=8'h0F, OUT_SET=8'hA0, OUT_CLR=8'h03 -> pio_out = 8'hAC.
   - Read addr 2 -> 0.
   - Write DATA_OUT=32'hFFFF_FF55 -> pio_out = 8'h55.
6. Reset mid-count: assert reset_n=0 for 1 cycle while ch1 has a partial debounce count (2 of 4) and pio_out=8'hAC -> stable = 4'hF, pio_out = 0, and the count restarts from 0.
